// File: rtl/sm83_pkg.sv
// Shared types and legality limits for the sm83 bus sequencer.
package sm83_pkg;

  localparam int ADR_WIDTH_DEF = 16;
  localparam int WORD_SIZE_DEF = 8;

  localparam int T_PER_M_MIN  = 3;
  localparam int T_PER_M_MAX  = 8;
  localparam int WAIT_MAX_MIN = 1;
  localparam int WAIT_MAX_MAX = 255;

  typedef logic [ADR_WIDTH_DEF-1:0] adr_t;
  typedef logic [WORD_SIZE_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    WAIT  = 2'd3
  } bus_state_t;

endpackage

// File: rtl/sm83_tphase_ring.sv
// One-hot T-state ring: advances one T-state per clock, wraps after
// T_PER_M, freezes while hold is high, and derives phi and m_end.
module sm83_tphase_ring
  import sm83_pkg::*;
#(
  parameter int T_PER_M = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               stall,
  output logic [T_PER_M-1:0] t_phase,
  output logic               phi,
  output logic               m_end
);

  localparam int PHI_T = (T_PER_M + 1) / 2;

  if (T_PER_M < T_PER_M_MIN || T_PER_M > T_PER_M_MAX) begin : g_bad_tpm
    $error("sm83_tphase_ring: T_PER_M outside the legal range");
  end

  logic [T_PER_M-1:0] phase_q, phase_d;
  logic               run_q, run_d;

  // Next phase: the first edge after reset release only arms the ring so
  // that T1 is held for one full clock; afterwards rotate unless held.
  always_comb begin
    phase_d = phase_q;
    run_d   = 1'b1;
    if (run_q && !hold) begin
      phase_d = {phase_q[T_PER_M-2:0], phase_q[T_PER_M-1]};
    end
  end

  // Ring state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= {{(T_PER_M-1){1'b0}}, 1'b1};
      run_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      run_q   <= run_d;
    end
  end

  assign t_phase = phase_q;
  assign phi     = |phase_q[PHI_T-1:0];
  assign m_end   = phase_q[T_PER_M-1] && !stall;

endmodule

// File: rtl/sm83_bus_seq.sv
// sm83 bus sequencer: one external memory access per M-cycle with
// configurable T-states, ready-driven wait states and wait timeout.
module sm83_bus_seq
  import sm83_pkg::*;
#(
  parameter int ADR_WIDTH = 16,
  parameter int WORD_SIZE = 8,
  parameter int T_PER_M   = 4,
  parameter int WAIT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_rd,
  input  logic                 req_wr,
  input  logic [ADR_WIDTH-1:0] req_adr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 rdata_valid,
  output logic                 m_end,
  output logic [T_PER_M-1:0]   t_phase,
  output logic                 stall,
  output logic                 err,
  output logic                 phi,
  output logic [ADR_WIDTH-1:0] adr,
  output logic [WORD_SIZE-1:0] dout,
  input  logic [WORD_SIZE-1:0] din,
  input  logic                 ready,
  output logic                 lh,
  output logic                 p_rd,
  output logic                 n_rd,
  output logic                 p_wr,
  output logic                 n_wr
);

  if (WAIT_MAX < WAIT_MAX_MIN || WAIT_MAX > WAIT_MAX_MAX) begin : g_bad_wmax
    $error("sm83_bus_seq: WAIT_MAX outside the legal range");
  end

  // Last wait clock before a forced completion.
  localparam logic [7:0] WCNT_LAST = 8'(WAIT_MAX - 1);

  bus_state_t           state_q, state_d;
  logic                 acc_wr_q, acc_wr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [WORD_SIZE-1:0] dout_q, dout_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 rdata_valid_q, rdata_valid_d;
  logic                 lh_q, lh_d;
  logic                 err_q, err_d;
  logic [7:0]           wcnt_q, wcnt_d;

  logic in_wait;
  logic sample;
  logic wait_done;
  logic wait_timeout;
  logic ring_hold;

  // The ring must already be held on the edge that enters WAIT, so the hold
  // is decoded combinationally from ready rather than from state_q alone.
  always_comb begin
    in_wait      = (state_q == WAIT);
    sample       = ((state_q == READ) || (state_q == WRITE)) && t_phase[T_PER_M-2];
    wait_timeout = in_wait && !ready && (wcnt_q == WCNT_LAST);
    wait_done    = in_wait && (ready || (wcnt_q == WCNT_LAST));
    ring_hold    = (sample && !ready) || (in_wait && !wait_done);
  end

  sm83_tphase_ring #(
    .T_PER_M (T_PER_M)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .hold    (ring_hold),
    .stall   (in_wait),
    .t_phase (t_phase),
    .phi     (phi),
    .m_end   (m_end)
  );

  // Access sequencing: request capture at m_end, ready sampling at the end
  // of T(T_PER_M-1), wait counting and forced completion on timeout.
  always_comb begin
    state_d       = state_q;
    acc_wr_d      = acc_wr_q;
    wdata_d       = wdata_q;
    adr_d         = adr_q;
    dout_d        = dout_q;
    rdata_d       = rdata_q;
    wcnt_d        = wcnt_q;
    rdata_valid_d = 1'b0;
    lh_d          = 1'b0;
    err_d         = 1'b0;

    if (m_end) begin
      acc_wr_d = req_wr;
      wdata_d  = req_wdata;
      wcnt_d   = 8'd0;
      if (req_rd && req_wr) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (req_rd) begin
        state_d = READ;
        adr_d   = req_adr;
      end else if (req_wr) begin
        state_d = WRITE;
        adr_d   = req_adr;
      end else begin
        state_d = IDLE;
      end
    end else if (sample) begin
      if (ready) begin
        if (!acc_wr_q) begin
          rdata_d       = din;
          rdata_valid_d = 1'b1;
          lh_d          = 1'b1;
        end
      end else begin
        state_d = WAIT;
        wcnt_d  = 8'd0;
      end
    end else if (in_wait) begin
      if (wait_done) begin
        state_d = acc_wr_q ? WRITE : READ;
        wcnt_d  = 8'd0;
        err_d   = wait_timeout;
        if (!acc_wr_q) begin
          rdata_d       = ready ? din : '1;
          rdata_valid_d = 1'b1;
          lh_d          = 1'b1;
        end
      end else begin
        wcnt_d = wcnt_q + 8'd1;
      end
    end else if ((state_q == WRITE) && t_phase[0]) begin
      // Write data goes onto the bus from T2 onwards.
      dout_d = wdata_q;
    end
  end

  // Sequencer and bus output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      acc_wr_q      <= 1'b0;
      wdata_q       <= '0;
      adr_q         <= '0;
      dout_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      lh_q          <= 1'b0;
      err_q         <= 1'b0;
      wcnt_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      acc_wr_q      <= acc_wr_d;
      wdata_q       <= wdata_d;
      adr_q         <= adr_d;
      dout_q        <= dout_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      lh_q          <= lh_d;
      err_q         <= err_d;
      wcnt_q        <= wcnt_d;
    end
  end

  // Strobe decode: read strobe spans the whole M-cycle, write strobe the
  // inner T-states; both stay asserted through WAIT.
  always_comb begin
    p_rd = (state_q == READ) || (in_wait && !acc_wr_q);
    p_wr = ((state_q == WRITE) && !t_phase[0] && !t_phase[T_PER_M-1]) ||
           (in_wait && acc_wr_q);
  end

  assign n_rd        = !p_rd;
  assign n_wr        = !p_wr;
  assign stall       = in_wait;
  assign adr         = adr_q;
  assign dout        = dout_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign lh          = lh_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sm83_bus_seq.sv
// Scoreboard bench for sm83_bus_seq (T_PER_M=4, WAIT_MAX=15).
module tb_sm83_bus_seq;
  import sm83_pkg::*;

  localparam int TPM  = 4;
  localparam int WMAX = 15;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           req_rd = 1'b0;
  logic           req_wr = 1'b0;
  logic [15:0]    req_adr = '0;
  logic [7:0]     req_wdata = '0;
  logic [7:0]     rdata;
  logic           rdata_valid;
  logic           m_end;
  logic [TPM-1:0] t_phase;
  logic           stall;
  logic           err;
  logic           phi;
  logic [15:0]    adr;
  logic [7:0]     dout;
  logic [7:0]     din = '0;
  logic           ready = 1'b1;
  logic           lh;
  logic           p_rd, n_rd, p_wr, n_wr;

  sm83_bus_seq #(
    .ADR_WIDTH (16),
    .WORD_SIZE (8),
    .T_PER_M   (TPM),
    .WAIT_MAX  (WMAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_adr     (req_adr),
    .req_wdata   (req_wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .m_end       (m_end),
    .t_phase     (t_phase),
    .stall       (stall),
    .err         (err),
    .phi         (phi),
    .adr         (adr),
    .dout        (dout),
    .din         (din),
    .ready       (ready),
    .lh          (lh),
    .p_rd        (p_rd),
    .n_rd        (n_rd),
    .p_wr        (p_wr),
    .n_wr        (n_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    adr_t  a;
    word_t d;
  } xact_t;

  xact_t rd_q[$];
  xact_t wr_q[$];
  string err_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor: pops expected transactions as the DUT presents them.
  initial begin
    logic  prev_pwr;
    xact_t e;
    string s;
    prev_pwr = 1'b0;
    forever begin
      @(negedge clk);
      if (rdata_valid) begin
        if (rd_q.size() == 0) flag("rd_unexpected");
        else begin
          e = rd_q.pop_front();
          check("rd_data", rdata, e.d);
          check("rd_adr", adr, e.a);
          check("rd_lh", lh, 1);
        end
      end
      if (p_wr && !prev_pwr) begin
        if (wr_q.size() == 0) flag("wr_unexpected");
        else begin
          e = wr_q.pop_front();
          check("wr_adr", adr, e.a);
          check("wr_dout", dout, e.d);
        end
      end
      prev_pwr = p_wr;
      if (err) begin
        if (err_q.size() == 0) flag("err_unexpected");
        else begin
          s = err_q.pop_front();
          check({"err_", s}, err, 1);
        end
      end
    end
  end

  task automatic wait_mend();
    for (int i = 0; i < 40; i++) begin
      if (m_end) return;
      @(negedge clk);
    end
    flag("wait_mend_timeout");
  endtask

  // Drive a request during the m_end T-state; returns at the next T1.
  task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    wait_mend();
    req_rd    = rd;
    req_wr    = wr;
    req_adr   = a;
    req_wdata = d;
    @(negedge clk);
    req_rd = 1'b0;
    req_wr = 1'b0;
  endtask

  // From T1, run to the next m_end; counts clocks and wait clocks, checks
  // frozen phase and held strobe, and raises ready after rel_at waits.
  task automatic run_to_mend(input int rel_at, input logic [7:0] rel_din, input logic is_wr,
                             output int ncyc, output int nstall);
    bit done;
    ncyc   = 1;
    nstall = 0;
    done   = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      ncyc++;
      if (stall) begin
        nstall++;
        check("wait_phase", t_phase, 4'b0100);
        check("wait_strobe", is_wr ? p_wr : p_rd, 1);
        if (nstall == rel_at) begin
          ready = 1'b1;
          din   = rel_din;
        end
      end
      if (m_end) done = 1;
    end
    if (!done) flag("mend_timeout");
  endtask

  int exp_ph[8]  = '{1, 2, 4, 8, 1, 2, 4, 8};
  int exp_phi[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  int exp_me[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    int nc, ns;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tphase", t_phase, 1);
    check("rst_phi", phi, 1);
    check("rst_ctrl", {m_end, stall, err, lh, rdata_valid}, 0);
    check("rst_strobes", {p_rd, n_rd, p_wr, n_wr}, 4'b0101);
    check("rst_adr", adr, 0);
    check("rst_dout", dout, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b1;

    // 1: free-running ring, no requests
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("ring_tphase", t_phase, exp_ph[i]);
      check("ring_phi", phi, exp_phi[i]);
      check("ring_mend", m_end, exp_me[i]);
      check("ring_strobes", {p_rd, n_rd, p_wr, n_wr}, 4'b0101);
    end

    // 2: read 0xC000, din=0x5A
    din = 8'h5A;
    rd_q.push_back('{16'hC000, 8'h5A});
    issue(1, 0, 16'hC000, 8'h00);
    check("rd_t1_phase", t_phase, 1);
    check("rd_t1_prd", p_rd, 1);
    check("rd_t1_adr", adr, 16'hC000);
    @(negedge clk);
    check("rd_t2_prd", p_rd, 1);
    @(negedge clk);
    check("rd_t3_prd", p_rd, 1);
    check("rd_t3_valid", rdata_valid, 0);
    check("rd_t3_lh", lh, 0);
    @(negedge clk);
    check("rd_t4_prd", p_rd, 1);
    check("rd_t4_lh", lh, 1);
    check("rd_t4_mend", m_end, 1);

    // 3: write 0xFF40/0x91, then back-to-back read 0x0100
    wr_q.push_back('{16'hFF40, 8'h91});
    issue(0, 1, 16'hFF40, 8'h91);
    check("wr_t1_adr", adr, 16'hFF40);
    check("wr_t1_strobes", {p_rd, p_wr}, 2'b00);
    check("wr_t1_dout", dout, 0);
    @(negedge clk);
    check("wr_t2_pwr", p_wr, 1);
    check("wr_t2_dout", dout, 8'h91);
    @(negedge clk);
    check("wr_t3_pwr", p_wr, 1);
    @(negedge clk);
    check("wr_t4_pwr", p_wr, 0);
    check("wr_t4_dout", dout, 8'h91);
    din = 8'h3C;
    rd_q.push_back('{16'h0100, 8'h3C});
    issue(1, 0, 16'h0100, 8'h00);
    check("b2b_t1_adr", adr, 16'h0100);
    check("b2b_t1_prd", p_rd, 1);
    run_to_mend(0, 8'h00, 0, nc, ns);
    check("b2b_len", nc, 4);

    // 4: read with three wait clocks; din valid only on the releasing clock
    ready = 1'b0;
    din   = 8'h11;
    rd_q.push_back('{16'h1234, 8'hA7});
    issue(1, 0, 16'h1234, 8'h00);
    run_to_mend(3, 8'hA7, 0, nc, ns);
    check("w3_len", nc, 7);
    check("w3_stalls", ns, 3);
    check("w3_phase_end", t_phase, 8);

    // 5: timeout with ready stuck low
    ready = 1'b0;
    din   = 8'h55;
    rd_q.push_back('{16'h2000, 8'hFF});
    err_q.push_back("timeout");
    issue(1, 0, 16'h2000, 8'h00);
    run_to_mend(0, 8'h00, 0, nc, ns);
    check("to_stalls", ns, WMAX);
    check("to_len", nc, 19);
    check("to_err", err, 1);
    check("to_phase", t_phase, 8);
    ready = 1'b1;

    // Write with two wait clocks: strobe and data held
    ready = 1'b0;
    wr_q.push_back('{16'h4000, 8'hE5});
    issue(0, 1, 16'h4000, 8'hE5);
    run_to_mend(2, 8'h00, 1, nc, ns);
    check("ww_len", nc, 6);
    check("ww_stalls", ns, 2);
    check("ww_t4_pwr", p_wr, 0);
    check("ww_dout", dout, 8'hE5);

    // 6: illegal read+write request
    err_q.push_back("illegal");
    issue(1, 1, 16'h3333, 8'h77);
    check("ill_err", err, 1);
    check("ill_strobes", {p_rd, p_wr}, 2'b00);
    check("ill_adr_hold", adr, 16'h4000);
    run_to_mend(0, 8'h00, 0, nc, ns);
    check("ill_len", nc, 4);
    check("ill_err_gone", err, 0);
    check("ill_prd", p_rd, 0);

    // Reset asserted in the middle of WAIT
    ready = 1'b0;
    issue(1, 0, 16'h5555, 8'h00);
    repeat (3) @(negedge clk);
    check("mid_stall", stall, 1);
    check("mid_prd", p_rd, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_tphase", t_phase, 1);
    check("ar_phi", phi, 1);
    check("ar_ctrl", {m_end, stall, err, lh, rdata_valid}, 0);
    check("ar_strobes", {p_rd, n_rd, p_wr, n_wr}, 4'b0101);
    check("ar_adr", adr, 0);
    check("ar_dout", dout, 0);
    check("ar_rdata", rdata, 0);
    ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check("rd_q_left", rd_q.size(), 0);
    check("wr_q_left", wr_q.size(), 0);
    check("err_q_left", err_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sm83_bus_seq.md
Name: sm83_bus_seq

Overview:
Parametrised bus sequencer for the sm83 core family. It generates the T-state phase ring and runs one memory access per M-cycle on the external bus.
New relative to the fixed 4-T interface: configurable T-states per M-cycle, an external `ready` input that inserts wait states, and a wait-timeout with error reporting.
Sits between the core control unit (request side) and the external memory bus.

Parameters:
ADR_WIDTH, 16, address bus width in bits
WORD_SIZE, 8, data bus width in bits
T_PER_M, 4, T-states per M-cycle; legal range 3..8
WAIT_MAX, 15, maximum inserted wait states before timeout; legal range 1..255

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_rd  in  1  core requests a read in the next M-cycle
req_wr  in  1  core requests a write in the next M-cycle
req_adr  in  ADR_WIDTH  request address
req_wdata  in  WORD_SIZE  write data
rdata  out  WORD_SIZE  latched read data
rdata_valid  out  1  one-clock pulse when rdata is updated
m_end  out  1  high during the last T-state of an M-cycle; requests are sampled here
t_phase  out  T_PER_M  one-hot current T-state (bit0 = T1)
stall  out  1  high while a wait state is active; the core freezes its sequencing
err  out  1  one-clock pulse on timeout or illegal request
phi  out  1  CPU clock phase output
adr  out  ADR_WIDTH  external address
dout  out  WORD_SIZE  external write data
din  in  WORD_SIZE  external read data
ready  in  1  external ready; low inserts wait states
lh  out  1  data latch hold
p_rd, n_rd  out  1 each  read strobe, true and complement
p_wr, n_wr  out  1 each  write strobe, true and complement

Behaviour:
- Reset (reset=0, asynchronous) forces all outputs to these values:
  - t_phase=1 (T1), state IDLE, wait count 0
  - adr=0, dout=0, rdata=0
  - rdata_valid=0, err=0, stall=0, m_end=0, lh=0
  - p_rd=0, p_wr=0, n_rd=1, n_wr=1
  - phi=1
  - Deassertion takes effect on the next clk edge. First T1 begins on the first edge after release.
- n_rd = !p_rd and n_wr = !p_wr at all times, combinationally.
- Phase ring: advances one T-state per clk and wraps from T_PER_M to T1.
  - Ring holds while in WAIT.
  - phi=1 for T-states 1..ceil(T_PER_M/2), else 0.
  - m_end = (last T-state) && !stall.
- Request capture: when m_end=1, registers req_rd, req_wr, req_adr and req_wdata for the next M-cycle.
  - req_rd && req_wr together: treated as IDLE, err pulses for one clock.
  - No request: IDLE.
- States:
  - IDLE: no strobes. adr holds its last value.
  - READ:
    - adr valid from T1 through the last T.
    - p_rd=1 from T1 through the last T.
    - Sample point is the clock ending T(T_PER_M-1).
    - If ready=1 at the sample point: rdata<=din, rdata_valid pulses for one clock, lh=1 from the next T through the end of the M-cycle.
    - If ready=0 at the sample point: go to WAIT.
  - WRITE:
    - adr valid from T1.
    - dout=wdata from T2 through the last T.
    - p_wr=1 from T2 through T(T_PER_M-1).
    - Same ready sample point as READ; ready=0 goes to WAIT with p_wr held.
  - WAIT:
    - stall=1; phase frozen at T(T_PER_M-1); strobes, adr and dout held.
    - Wait count increments each clock.
    - ready=1: completes as the normal sample (read latches din), count clears, phase resumes at the last T.
    - Count reaches WAIT_MAX with ready still 0: forced completion. A read returns all-ones. err pulses. Phase resumes.
- Back-to-back accesses: no idle clock is inserted; adr changes at the T1 edge.
- ready is ignored outside the sample point and WAIT.

Decomposition:
- Shared package sm83_pkg holds:
  - word_t / adr_t typedefs parametrised on WORD_SIZE / ADR_WIDTH
  - the bus_state_t enum {IDLE, READ, WRITE, WAIT}
  - T_PER_M_MIN/MAX legality constants
- One natural sub-module: sm83_tphase_ring. It owns the one-hot phase ring, phi, m_end and the hold input, and is parametrised by T_PER_M.

Test Plan:
1. Reset release, T_PER_M=4, no requests -> t_phase cycles 1,2,4,8,1…; phi=1,1,0,0; m_end high every 4th clock; all strobes idle; n_rd=n_wr=1.
2. Read 0xC000 with din=0x5A, ready=1 -> p_rd high T1–T4; rdata=0x5A with rdata_valid pulse at end of T3; lh high in T4.
3. Write 0xFF40 data 0x91 followed by a read to 0x0100 -> p_wr high T2–T3, dout=0x91 T2–T4; back-to-back read starts with adr=0x0100 in the next T1.
4. Read with ready low for 3 clocks -> stall high 3 clocks, phase frozen at T3, din latched on the clock ready=1, cycle length 7 clocks.
5. WAIT_MAX=15 with ready stuck low -> forced completion after 15 wait clocks, rdata=0xFF, err one-clock pulse, phase resumes.
6. req_rd and req_wr both high -> err pulse, no strobes. Then reset asserted mid-WAIT -> all outputs return to reset values immediately (asynchronously).
